// File: rtl/axi_lite_csr_responder.sv
// AXI-Lite register file: NUM_REGS x 32-bit CSRs with byte strobes and per-register write pulses.
// Build option: define AXI_LITE_CSR_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.

package fpga_pkg;

  typedef struct packed {
    logic [12:0] aw_addr;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [12:0] ar_addr;
    logic        ar_valid;
    logic        r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
  } axi_lite_resp_t;

endpackage

module axi_lite_csr_responder
  import fpga_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  axi_lite_req_t            axi_req_i,
  output axi_lite_resp_t           axi_resp_o,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_CSR_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  typedef enum logic { W_IDLE, W_RESP } w_state_e;
  typedef enum logic { R_IDLE, R_RESP } r_state_e;

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic f_mapped(input logic [10:0] idx);
    return ({21'd0, idx} < 32'(NUM_REGS));
  endfunction

  // ---------------------------------------------------------------- write path
  w_state_e    r_wstate, w_wstate_nxt;
  logic        r_aw_held, r_w_held;
  logic [12:0] r_aw_addr;
  logic [31:0] r_w_data;
  logic [3:0]  r_w_strb;
  logic [1:0]  r_b_resp;

  logic        w_aw_ready, w_w_ready;
  logic        w_aw_hs, w_w_hs, w_commit, w_b_hs;
  logic [12:0] w_wr_addr;
  logic [31:0] w_wr_data;
  logic [3:0]  w_wr_strb;
  logic [10:0] w_wr_idx;
  logic        w_wr_mapped;
  logic [NUM_REGS-1:0] w_wr_hit;

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_ready   = 1'b0;
    w_w_ready    = 1'b0;
    w_commit     = 1'b0;
    w_b_hs       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_aw_ready = !r_aw_held;
        w_w_ready  = !r_w_held;
        // Commit as soon as both halves are available, latched or arriving now.
        if ((r_aw_held || axi_req_i.aw_valid) && (r_w_held || axi_req_i.w_valid)) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (axi_req_i.b_ready) begin
          w_b_hs       = 1'b1;
          w_wstate_nxt = W_IDLE;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  assign w_aw_hs     = w_aw_ready && axi_req_i.aw_valid;
  assign w_w_hs      = w_w_ready && axi_req_i.w_valid;
  assign w_wr_addr   = r_aw_held ? r_aw_addr : axi_req_i.aw_addr;
  assign w_wr_data   = r_w_held ? r_w_data : axi_req_i.w_data;
  assign w_wr_strb   = r_w_held ? r_w_strb : axi_req_i.w_strb;
  assign w_wr_idx    = w_wr_addr[12:2];
  assign w_wr_mapped = f_mapped(w_wr_idx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_b_resp  <= RESP_OKAY;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) r_aw_held <= 1'b1;
      if (w_w_hs)  r_w_held  <= 1'b1;
      if (w_b_hs) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end
      if (w_commit) r_b_resp <= w_wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
    end
  end

  // Payload holding registers are qualified by the held flags, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (w_aw_hs) r_aw_addr <= axi_req_i.aw_addr;
    if (w_w_hs) begin
      r_w_data <= axi_req_i.w_data;
      r_w_strb <= axi_req_i.w_strb;
    end
  end

  // ------------------------------------------------------------- register bank
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    logic [31:0] r_reg;
    logic        r_pulse;

    assign w_wr_hit[k] = w_commit && w_wr_mapped && (w_wr_idx == 11'(k));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_reg   <= RESET_VAL;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_wr_hit[k];
        if (w_wr_hit[k]) r_reg <= f_merge(r_reg, w_wr_data, w_wr_strb);
      end
    end

    assign regs_o[32*k +: 32] = r_reg;
    assign wr_pulse_o[k]      = r_pulse;
  end

  // ----------------------------------------------------------------- read path
  r_state_e    r_rstate, w_rstate_nxt;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs;
  logic [10:0] w_rd_idx;
  logic [31:0] w_rd_word;

  assign w_rd_idx = axi_req_i.ar_addr[12:2];

  // Unmapped indices match no register and therefore read as zero.
  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_rd_idx == 11'(k)) w_rd_word = regs_o[32*k +: 32];
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ar_hs      = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (axi_req_i.ar_valid) begin
          w_ar_hs      = 1'b1;
          w_rstate_nxt = R_RESP;
        end
      end
      R_RESP: begin
        if (axi_req_i.r_ready) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rd_word;
        r_rresp <= f_mapped(w_rd_idx) ? RESP_OKAY : RESP_UNMAPPED;
      end
    end
  end

  // ------------------------------------------------------------------- outputs
  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = w_aw_ready;
    axi_resp_o.w_ready  = w_w_ready;
    axi_resp_o.b_valid  = (r_wstate == W_RESP);
    axi_resp_o.b_resp   = r_b_resp;
    axi_resp_o.ar_ready = (r_rstate == R_IDLE);
    axi_resp_o.r_valid  = (r_rstate == R_RESP);
    axi_resp_o.r_data   = r_rdata;
    axi_resp_o.r_resp   = r_rresp;
  end

  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{axi_req_i.aw_addr[1:0], axi_req_i.ar_addr[1:0], r_aw_addr[1:0]};

endmodule

// File: doc/axi_lite_csr_responder.md
AXI_LITE_CSR_RESPONDER -- requirements
Module: axi_lite_csr_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit read/write registers (1..2048).
REQ-002 SHALL have parameter RESET_VAL, default 32'h0, reset value of every register.
REQ-003 SHALL have port clk_i, input, 1, single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port axi_req_i, input, fpga_pkg::axi_lite_req_t, AXI-Lite request channels (13-bit address, 32-bit data, 4-bit strobe).
REQ-006 SHALL have port axi_resp_o, output, fpga_pkg::axi_lite_resp_t, AXI-Lite response channels.
REQ-007 SHALL have port regs_o, output, NUM_REGS*32, current register contents; register k on bits [32k+31:32k].
REQ-008 SHALL have port wr_pulse_o, output, NUM_REGS, one-cycle strobe per register on committed write.

Function
REQ-009 SHALL decode register index as addr[12:2]; addr[1:0] ignored; address mapped iff index < NUM_REGS.
REQ-010 Write path SHALL have states W_IDLE and W_RESP; reset state W_IDLE.
REQ-011 In W_IDLE, aw_ready SHALL be 1 while no AW is latched, and w_ready 1 while no W is latched; AW and W are accepted independently, in either order or in the same cycle.
REQ-012 When both AW and W are held (including when accepted in the same cycle), the write SHALL commit at the next edge: bytes with strobe 1 updated, others kept; FSM goes to W_RESP; b_valid=1 from that cycle.
REQ-013 In W_RESP, aw_ready=w_ready=0; b_valid and b_resp SHALL stay stable until b_ready; on handshake, return to W_IDLE and clear latches; next AW/W acceptance possible the following cycle.
REQ-014 wr_pulse_o[k] SHALL be 1 for exactly the cycle after commit to mapped register k; strobe 4'b0000 still commits and pulses.
REQ-015 Read path SHALL have states R_IDLE and R_RESP; ar_ready=1 only in R_IDLE.
REQ-016 On AR handshake at edge N, r_data SHALL be captured from the register value before edge N and r_valid=1 from cycle N+1; r_data/r_resp stable until r_ready; then R_IDLE.
REQ-017 Simultaneous read handshake and write commit to the same register SHALL return the old value; regs_o shows the new value in the next cycle.
REQ-018 Read and write paths SHALL be independent; neither stalls the other.
REQ-019 Unmapped write SHALL modify nothing and raise no wr_pulse_o; unmapped read SHALL return r_data=0.
REQ-020 Mapped accesses SHALL respond OKAY (2'b00).

Reset
REQ-021 Asserting rst_ni low SHALL immediately set: registers=RESET_VAL, wr_pulse_o=0, b_valid=0, r_valid=0, b_resp=r_resp=0, r_data=0, both FSMs idle, AW/W latches cleared.
REQ-022 During and right after reset, aw_ready=w_ready=ar_ready=1.
REQ-023 Reset mid-transaction SHALL abandon it: no B or R issued afterwards, and a half-latched write is discarded.

Configuration
REQ-024 Macro AXI_LITE_CSR_SLVERR_EN defined: unmapped read/write SHALL respond SLVERR (2'b10).
REQ-025 Macro undefined: unmapped read/write SHALL respond OKAY (2'b00); REQ-019 data behaviour unchanged.

Verification
REQ-026 Same-cycle AW addr 0x008 + W data 0xDEADBEEF strb 4'hF, b_ready=1 -> regs_o[2]=0xDEADBEEF, wr_pulse_o[2] single cycle, b_valid next cycle, b_resp=OKAY.
REQ-027 W data 0x11223344 strb 4'b0101 three cycles before AW addr 0x004, register initially 0 -> no commit until AW; then reg1=0x00220044.
REQ-028 AR 0x008 on the same edge as a write commit to 0x008 -> r_data is the old value, with r_ready held low 5 cycles, r_valid/r_data stable throughout.
REQ-029 NUM_REGS=16, write then read addr 0x040 -> no register changes, r_data=0, resp=2'b10 with AXI_LITE_CSR_SLVERR_EN, 2'b00 without.
REQ-030 rst_ni low while b_valid=1 pending and an AR is latched -> b_valid=r_valid=0 immediately; all regs=RESET_VAL; no responses after release.
REQ-031 Back-to-back writes with b_ready=1 -> aw_ready=0 during W_RESP; throughput one write per 2 cycles; every wr_pulse_o one cycle wide.
